neuron_sequencer: RTL and testbench

Control FSM that drives one NeuronCalculator through a full image inference. It walks the pixel/weight memories word by word, asserting the neuron's enable and get_result at the right cycles, then captures the 1-bit classification. It sits between the top-level start/abort control and the pixel ROM, weight ROM and NeuronCalculator. Memory data goes straight from the ROMs to the neuron; this block only drives addresses and strobes.

---
 rtl/cat_recognizer_pkg.sv | 18 +
 rtl/seq_addr_counter.sv | 40 ++++
 rtl/neuron_sequencer.sv | 146 ++++++++++++++
 tb/tb_neuron_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cat_recognizer_pkg.sv
// Shared types and constants for the cat recognizer: sequencer state encoding
// and the default image size in memory words.
package cat_recognizer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_RESULT  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_DONE    = 3'd5,
      ST_FLUSH   = 3'd6
   } seq_state_e;

   // 64x64 RGB image, three 8-bit pixels per memory word.
   localparam int NUM_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/seq_addr_counter.sv
// Word address counter for the pixel/weight ROMs; saturates at NUM_WORDS-1
// and flags the last word so the sequencer can leave FETCH.
module seq_addr_counter #(
   parameter int Addr_Depth = 12,
   parameter int NUM_WORDS  = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  inc,
   output logic [Addr_Depth-1:0] addr,
   output logic                  last
);

   localparam logic [Addr_Depth-1:0] LAST_ADDR = Addr_Depth'(NUM_WORDS - 1);

   logic [Addr_Depth-1:0] addr_q;
   logic [Addr_Depth-1:0] addr_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (clear) begin
         addr_d = '0;
      end else if (inc && !last) begin
         addr_d = addr_q + 1'b1;
      end
   end

   assign last = (addr_q == LAST_ADDR);
   assign addr = addr_q;

endmodule

// File: rtl/neuron_sequencer.sv
// Drives one NeuronCalculator through a full image: address/read strobes,
// enable, get_result and classification capture. Optional NEURON_SEQ_PERF_EN
// adds a 32-bit busy-cycle counter output.
module neuron_sequencer
   import cat_recognizer_pkg::*;
#(
   parameter int DATA_WIDTH       = 24,
   parameter int Addr_Depth       = 12,
   parameter int Weight_Percision = 5,
   parameter int NUM_WORDS        = NUM_WORDS_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [Addr_Depth-1:0] mem_addr,
   output logic                  mem_rd_en,
   output logic                  neuron_enable,
   output logic                  neuron_get_result,
   input  logic                  neuron_out1,
   output logic                  busy,
   output logic                  done,
   output logic                  result,
   output logic                  result_valid,
   output seq_state_e            dbg_state
`ifdef NEURON_SEQ_PERF_EN
   ,
   output logic [31:0]           cycle_count
`endif
);

   if (NUM_WORDS < 1 || NUM_WORDS > (1 << Addr_Depth) ||
       DATA_WIDTH % 3 != 0 || Weight_Percision < 1) begin : g_bad_cfg
      $error("neuron_sequencer: inconsistent sizing parameters");
   end

   seq_state_e state_q, state_d;
   logic       enable_q, enable_d;
   logic       result_q, result_d;
   logic       valid_q, valid_d;
   logic       accept;
   logic       start_accept;
   logic       capture_en;
   logic       addr_last;

   assign accept = start && !abort;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (accept) state_d = ST_FETCH;
         ST_FETCH:   if (abort) state_d = ST_FLUSH;
                     else if (addr_last) state_d = ST_DRAIN;
         ST_DRAIN:   state_d = abort ? ST_FLUSH : ST_RESULT;
         // The accumulator is cleared on the RESULT edge, so no flush is needed.
         ST_RESULT:  state_d = abort ? ST_IDLE : ST_CAPTURE;
         ST_CAPTURE: state_d = ST_DONE;
         ST_DONE:    state_d = accept ? ST_FETCH : ST_IDLE;
         ST_FLUSH:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_en         = (state_q == ST_FETCH);
      neuron_get_result = (state_q == ST_RESULT) || (state_q == ST_FLUSH);
      busy              = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                          (state_q == ST_RESULT) || (state_q == ST_CAPTURE);
      done              = (state_q == ST_DONE);
      capture_en        = (state_q == ST_CAPTURE);
      start_accept      = accept && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   end

   always_comb begin
      // ROM data lags the read strobe by one cycle; an abort kills the pending word.
      enable_d = mem_rd_en && !abort;
      result_d = capture_en ? neuron_out1 : result_q;
      valid_d  = valid_q;
      if (start_accept || state_q == ST_FLUSH) begin
         valid_d = 1'b0;
      end else if (capture_en) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enable_q <= 1'b0;
         result_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         enable_q <= enable_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   seq_addr_counter #(
      .Addr_Depth (Addr_Depth),
      .NUM_WORDS  (NUM_WORDS)
   ) u_addr (
      .clock (clock),
      .reset (reset),
      .clear (start_accept),
      .inc   (mem_rd_en),
      .addr  (mem_addr),
      .last  (addr_last)
   );

   assign neuron_enable = enable_q;
   assign result        = result_q;
   assign result_valid  = valid_q;
   assign dbg_state     = state_q;

`ifdef NEURON_SEQ_PERF_EN
   logic [31:0] cycle_q, cycle_d;

   always_comb begin
      cycle_d = cycle_q;
      if (start_accept) begin
         cycle_d = '0;
      end else if (busy) begin
         cycle_d = cycle_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer with NUM_WORDS=4: randomized runs,
// aborts and resets checked against a per-cycle timeline model.
module tb_neuron_sequencer;
   import cat_recognizer_pkg::*;

   localparam int N  = 4;
   localparam int AW = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          neuron_out1 = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en, neuron_enable, neuron_get_result;
   logic          busy, done, result, result_valid;
   seq_state_e    dbg_state;
`ifdef NEURON_SEQ_PERF_EN
   logic [31:0]   cycle_count;
`endif

   int         n_checks = 0;
   int         n_fail = 0;
   logic [0:0] exp_q[$];
   logic       model_valid = 1'b0;
   logic       model_res = 1'b0;
   int         cnt_model = 0;

   neuron_sequencer #(
      .DATA_WIDTH       (24),
      .Addr_Depth       (AW),
      .Weight_Percision (5),
      .NUM_WORDS        (N)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .mem_addr          (mem_addr),
      .mem_rd_en         (mem_rd_en),
      .neuron_enable     (neuron_enable),
      .neuron_get_result (neuron_get_result),
      .neuron_out1       (neuron_out1),
      .busy              (busy),
      .done              (done),
      .result            (result),
      .result_valid      (result_valid),
      .dbg_state         (dbg_state)
`ifdef NEURON_SEQ_PERF_EN
      ,
      .cycle_count       (cycle_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Where the run is, cycle by cycle after the accept edge, for abort offset a (0 = none).
   function automatic seq_state_e phase(int o, int a);
      seq_state_e s;
      if (o <= 0) return ST_IDLE;
      if (o <= N)          s = ST_FETCH;
      else if (o == N + 1) s = ST_DRAIN;
      else if (o == N + 2) s = ST_RESULT;
      else if (o == N + 3) s = ST_CAPTURE;
      else                 s = ST_DONE;
      if (a >= 1 && a <= N + 1 && o > a) s = (o == a + 1) ? ST_FLUSH : ST_IDLE;
      if (a == N + 2 && o > a) s = ST_IDLE;
      return s;
   endfunction

   function automatic logic is_busy(seq_state_e s);
      return (s == ST_FETCH) || (s == ST_DRAIN) || (s == ST_RESULT) || (s == ST_CAPTURE);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
      check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check_eq({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
      check_eq({tag, "_en"}, 32'(neuron_enable), 32'd0);
      check_eq({tag, "_get"}, 32'(neuron_get_result), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_res"}, 32'(result), 32'd0);
      check_eq({tag, "_rv"}, 32'(result_valid), 32'd0);
`ifdef NEURON_SEQ_PERF_EN
      check_eq({tag, "_cnt"}, cycle_count, 32'd0);
`endif
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
      check_eq({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
      check_eq({tag, "_en"}, 32'(neuron_enable), 32'd0);
      check_eq({tag, "_get"}, 32'(neuron_get_result), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_rv"}, 32'(result_valid), 32'(model_valid));
      check_eq({tag, "_res"}, 32'(result), 32'(model_res));
`ifdef NEURON_SEQ_PERF_EN
      check_eq({tag, "_cnt"}, cycle_count, 32'(cnt_model));
`endif
   endtask

   // n idle cycles; start is raised in the last one so the next edge accepts it.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         check_idle("idle");
         if (i == n - 1) begin
            start = 1'b1;
            abort = 1'b0;
         end else begin
            start = ($urandom_range(0, 2) == 0);
            abort = start | ($urandom_range(0, 3) == 0);
         end
      end
   endtask

   // One inference whose start is already on the bus; offsets 1..last_o are checked.
   task automatic run(input int a, input logic bitv, input bit chain, input int last_o);
      seq_state_e st, prv;
      string      t;
      cnt_model = 0;
      if (last_o == N + 4 && (a == 0 || a >= N + 3)) exp_q.push_back(bitv);
      for (int o = 1; o <= last_o; o++) begin
         @(negedge clock);
         st  = phase(o, a);
         prv = phase(o - 1, a);
         t   = $sformatf("o%0d_a%0d", o, a);
         if (st == ST_DONE) begin
            model_valid = 1'b1;
            model_res   = bitv;
         end else if (o == 1 || st == ST_FLUSH) begin
            model_valid = 1'b0;
         end
         check_eq({t, "_state"}, 32'(dbg_state), 32'(st));
         check_eq({t, "_rd"}, 32'(mem_rd_en), 32'(st == ST_FETCH));
         if (st == ST_FETCH) check_eq({t, "_addr"}, 32'(mem_addr), 32'(o - 1));
         check_eq({t, "_en"}, 32'(neuron_enable), 32'(prv == ST_FETCH && a != o - 1));
         check_eq({t, "_get"}, 32'(neuron_get_result), 32'(st == ST_RESULT || st == ST_FLUSH));
         check_eq({t, "_busy"}, 32'(busy), 32'(is_busy(st)));
         check_eq({t, "_done"}, 32'(done), 32'(st == ST_DONE));
         check_eq({t, "_rv"}, 32'(result_valid), 32'(model_valid));
         check_eq({t, "_res"}, 32'(result), 32'(model_res));
`ifdef NEURON_SEQ_PERF_EN
         check_eq({t, "_cnt"}, cycle_count, 32'(cnt_model));
`endif
         if (is_busy(st)) cnt_model++;
         abort       = (o == a);
         neuron_out1 = (o == N + 3) ? bitv : ~bitv;
         if (o == N + 4)                             start = chain;
         else if (is_busy(st) || st == ST_FLUSH)     start = 1'($urandom_range(0, 1));
         else                                        start = 1'b0;
      end
   endtask

   always @(negedge clock) begin
      if (reset && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 32'(done), 32'd0);
         end else begin
            logic [0:0] e;
            e = exp_q.pop_front();
            check_eq("sb_result", 32'(result), 32'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int   a;
      logic bitv;
      bit   ch;
      bit   chained;

      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b1;

      idle_cycles(2);
      run(0, 1'b1, 1'b0, N + 4);
      idle_cycles(2);
      run(0, 1'b0, 1'b1, N + 4);
      run(0, 1'b1, 1'b0, N + 4);
      idle_cycles(3);
      run(3, 1'b1, 1'b0, N + 4);
      idle_cycles(1);
      run(N + 3, 1'b0, 1'b0, N + 4);
      idle_cycles(2);
      run(N + 2, 1'b1, 1'b0, N + 4);
      idle_cycles(1);
      run(N + 1, 1'b0, 1'b0, N + 4);

      // Asynchronous reset while in DRAIN, away from any clock edge.
      idle_cycles(2);
      run(0, 1'b1, 1'b0, N + 1);
      start = 1'b0;
      abort = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_outputs("async_rst");
      model_valid = 1'b0;
      model_res   = 1'b0;
      cnt_model   = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      idle_cycles(2);
      run(0, 1'b1, 1'b0, N + 4);

      chained = 1'b0;
      for (int r = 0; r < 40; r++) begin
         a    = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, N + 4));
         bitv = 1'($urandom_range(0, 1));
         ch   = ($urandom_range(0, 2) == 0) && (a != N + 4) && (r != 39);
         if (!chained) idle_cycles(int'($urandom_range(1, 3)));
         run(a, bitv, ch, N + 4);
         chained = ch;
      end

      repeat (2) begin
         @(negedge clock);
         check_idle("tail");
      end
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
